// File: rtl/dram_entry_cache.sv
// -----------------------------------------------------------------------------
// dram_entry_cache
//
// Single-entry write-back cache that sits between the beverage-shop core and
// the DRAM bridge. The core issues full-record reads and writes. The bridge
// C_* handshake is used only for a miss fetch, a dirty write-back or a flush.
// Every accepted request gets exactly one response pulse.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req_valid/req_ready/req_wr/req_addr/req_data
//                   core request channel (accepted when valid & ready)
//   flush           write back the dirty entry; sampled only in IDLE when no
//                   request is presented (a request wins over a flush)
//   rsp_valid/rsp_data/rsp_hit
//                   one-cycle response pulse; writes echo the new entry data
//   flush_done      one-cycle pulse when a flush has completed
//   C_in_valid/C_r_wb/C_addr/C_data_w
//                   one-cycle command to the bridge (1=read, 0=write); the
//                   address, data and direction hold until the next command
//   C_data_r/C_out_valid
//                   bridge completion pulse with read data
//   hit_cnt/miss_cnt
//                   saturating hit and miss counters
//
// Every output is driven straight from a flop.
// -----------------------------------------------------------------------------
module dram_entry_cache #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              flush,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_hit,
  output logic              flush_done,
  output logic              C_in_valid,
  output logic              C_r_wb,
  output logic [ADDR_W-1:0] C_addr,
  output logic [DATA_W-1:0] C_data_w,
  input  logic [DATA_W-1:0] C_data_r,
  input  logic              C_out_valid,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WB_ISSUE = 3'd1,
    WB_WAIT  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    RESP     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_r;
  state_t state_nx_s;

  // Cache entry
  logic              valid_r;
  logic              dirty_r;
  logic [ADDR_W-1:0] tag_r;
  logic [DATA_W-1:0] data_r;
  logic              valid_nx_s;
  logic              dirty_nx_s;
  logic [ADDR_W-1:0] tag_nx_s;
  logic [DATA_W-1:0] data_nx_s;

  // Operation latched at accept time, consumed after the bridge round trips
  logic              op_wr_r;
  logic [ADDR_W-1:0] op_addr_r;
  logic [DATA_W-1:0] op_data_r;
  logic              op_flush_r;

  // Registered outputs and their next values
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic              rsp_hit_r;
  logic              flush_done_r;
  logic              c_in_valid_r;
  logic              c_r_wb_r;
  logic [ADDR_W-1:0] c_addr_r;
  logic [DATA_W-1:0] c_data_w_r;
  logic [CNT_W-1:0]  hit_cnt_r;
  logic [CNT_W-1:0]  miss_cnt_r;

  logic              req_ready_nx_s;
  logic              rsp_valid_nx_s;
  logic [DATA_W-1:0] rsp_data_nx_s;
  logic              rsp_hit_nx_s;
  logic              flush_done_nx_s;
  logic              c_in_valid_nx_s;
  logic              c_r_wb_nx_s;
  logic [ADDR_W-1:0] c_addr_nx_s;
  logic [DATA_W-1:0] c_data_w_nx_s;
  logic [CNT_W-1:0]  hit_cnt_nx_s;
  logic [CNT_W-1:0]  miss_cnt_nx_s;

  // Request and flush qualification (req_ready is high exactly in IDLE)
  logic accept_s;
  logic hit_s;
  logic flush_go_s;
  logic wb_done_s;
  logic rd_done_s;

  assign accept_s   = (state_r == IDLE) & req_valid;
  assign hit_s      = valid_r & (tag_r == req_addr);
  assign flush_go_s = (state_r == IDLE) & flush & ~req_valid;
  assign wb_done_s  = (state_r == WB_WAIT) & C_out_valid;
  assign rd_done_s  = (state_r == RD_WAIT) & C_out_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (hit_s) begin
            state_nx_s = RESP;
          end else if (dirty_r) begin
            state_nx_s = WB_ISSUE;
          end else if (req_wr) begin
            state_nx_s = RESP;
          end else begin
            state_nx_s = RD_ISSUE;
          end
        end else if (flush_go_s && dirty_r) begin
          state_nx_s = WB_ISSUE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      WB_ISSUE: state_nx_s = WB_WAIT;
      WB_WAIT: begin
        if (C_out_valid) begin
          if (op_flush_r) begin
            state_nx_s = IDLE;
          end else if (op_wr_r) begin
            state_nx_s = RESP;
          end else begin
            state_nx_s = RD_ISSUE;
          end
        end else begin
          state_nx_s = WB_WAIT;
        end
      end
      RD_ISSUE: state_nx_s = RD_WAIT;
      RD_WAIT: begin
        if (C_out_valid) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = RD_WAIT;
        end
      end
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Next value of the cache entry
  always_comb begin
    valid_nx_s = valid_r;
    dirty_nx_s = dirty_r;
    tag_nx_s   = tag_r;
    data_nx_s  = data_r;
    if (accept_s) begin
      if (hit_s) begin
        if (req_wr) begin
          data_nx_s  = req_data;
          dirty_nx_s = 1'b1;
        end else begin
          dirty_nx_s = dirty_r;
        end
      end else if (!dirty_r && req_wr) begin
        // Write miss over a clean entry installs without a fetch
        valid_nx_s = 1'b1;
        dirty_nx_s = 1'b1;
        tag_nx_s   = req_addr;
        data_nx_s  = req_data;
      end else begin
        dirty_nx_s = dirty_r;
      end
    end else if (wb_done_s) begin
      dirty_nx_s = 1'b0;
      if (!op_flush_r && op_wr_r) begin
        valid_nx_s = 1'b1;
        dirty_nx_s = 1'b1;
        tag_nx_s   = op_addr_r;
        data_nx_s  = op_data_r;
      end else begin
        valid_nx_s = valid_r;
      end
    end else if (rd_done_s) begin
      valid_nx_s = 1'b1;
      dirty_nx_s = 1'b0;
      tag_nx_s   = op_addr_r;
      data_nx_s  = C_data_r;
    end else begin
      valid_nx_s = valid_r;
    end
  end

  // Next value of every registered output
  always_comb begin
    req_ready_nx_s  = (state_nx_s == IDLE);
    rsp_valid_nx_s  = (state_nx_s == RESP);
    rsp_hit_nx_s    = accept_s & hit_s;
    rsp_data_nx_s   = rsp_data_r;
    flush_done_nx_s = (flush_go_s & ~dirty_r) | (wb_done_s & op_flush_r);
    c_in_valid_nx_s = (state_nx_s == WB_ISSUE) | (state_nx_s == RD_ISSUE);
    c_r_wb_nx_s     = c_r_wb_r;
    c_addr_nx_s     = c_addr_r;
    c_data_w_nx_s   = c_data_w_r;
    hit_cnt_nx_s    = hit_cnt_r;
    miss_cnt_nx_s   = miss_cnt_r;

    if (state_nx_s == RESP) begin
      rsp_data_nx_s = data_nx_s;
    end else begin
      rsp_data_nx_s = rsp_data_r;
    end

    // Bridge command fields are loaded only on the way into an issue state
    case (state_nx_s)
      WB_ISSUE: begin
        c_r_wb_nx_s   = 1'b0;
        c_addr_nx_s   = tag_r;
        c_data_w_nx_s = data_r;
      end
      RD_ISSUE: begin
        c_r_wb_nx_s = 1'b1;
        if (state_r == IDLE) begin
          c_addr_nx_s = req_addr;
        end else begin
          c_addr_nx_s = op_addr_r;
        end
      end
      default: begin
        c_r_wb_nx_s = c_r_wb_r;
      end
    endcase

    if (accept_s && hit_s && (hit_cnt_r != CNT_MAX)) begin
      hit_cnt_nx_s = hit_cnt_r + CNT_ONE;
    end else begin
      hit_cnt_nx_s = hit_cnt_r;
    end
    if (accept_s && !hit_s && (miss_cnt_r != CNT_MAX)) begin
      miss_cnt_nx_s = miss_cnt_r + CNT_ONE;
    end else begin
      miss_cnt_nx_s = miss_cnt_r;
    end
  end

  // Entry, latched operation and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r      <= 1'b0;
      dirty_r      <= 1'b0;
      tag_r        <= {ADDR_W{1'b0}};
      data_r       <= {DATA_W{1'b0}};
      op_wr_r      <= 1'b0;
      op_addr_r    <= {ADDR_W{1'b0}};
      op_data_r    <= {DATA_W{1'b0}};
      op_flush_r   <= 1'b0;
      req_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= {DATA_W{1'b0}};
      rsp_hit_r    <= 1'b0;
      flush_done_r <= 1'b0;
      c_in_valid_r <= 1'b0;
      c_r_wb_r     <= 1'b0;
      c_addr_r     <= {ADDR_W{1'b0}};
      c_data_w_r   <= {DATA_W{1'b0}};
      hit_cnt_r    <= {CNT_W{1'b0}};
      miss_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      valid_r      <= valid_nx_s;
      dirty_r      <= dirty_nx_s;
      tag_r        <= tag_nx_s;
      data_r       <= data_nx_s;
      if (accept_s) begin
        op_wr_r    <= req_wr;
        op_addr_r  <= req_addr;
        op_data_r  <= req_data;
        op_flush_r <= 1'b0;
      end else if (flush_go_s) begin
        op_flush_r <= 1'b1;
      end else begin
        op_flush_r <= op_flush_r;
      end
      req_ready_r  <= req_ready_nx_s;
      rsp_valid_r  <= rsp_valid_nx_s;
      rsp_data_r   <= rsp_data_nx_s;
      rsp_hit_r    <= rsp_hit_nx_s;
      flush_done_r <= flush_done_nx_s;
      c_in_valid_r <= c_in_valid_nx_s;
      c_r_wb_r     <= c_r_wb_nx_s;
      c_addr_r     <= c_addr_nx_s;
      c_data_w_r   <= c_data_w_nx_s;
      hit_cnt_r    <= hit_cnt_nx_s;
      miss_cnt_r   <= miss_cnt_nx_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_hit    = rsp_hit_r;
  assign flush_done = flush_done_r;
  assign C_in_valid = c_in_valid_r;
  assign C_r_wb     = c_r_wb_r;
  assign C_addr     = c_addr_r;
  assign C_data_w   = c_data_w_r;
  assign hit_cnt    = hit_cnt_r;
  assign miss_cnt   = miss_cnt_r;

endmodule

// File: tb/tb_dram_entry_cache.sv
// Directed bench for dram_entry_cache. A tiny bridge model answers each
// C_in_valid after a chosen number of cycles; expected values are written
// out by hand next to each operation.
module tb_dram_entry_cache;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [7:0]  req_addr;
  logic [63:0] req_data;
  logic        flush;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_hit;
  logic        flush_done;
  logic        C_in_valid;
  logic        C_r_wb;
  logic [7:0]  C_addr;
  logic [63:0] C_data_w;
  logic [63:0] C_data_r;
  logic        C_out_valid;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Results of the most recent run_op
  logic [63:0] got_data;
  logic        got_hit;
  int          got_lat;
  int          ncmd;
  logic        cmd_rwb  [0:3];
  logic [7:0]  cmd_addr [0:3];
  logic [63:0] cmd_dataw[0:3];

  dram_entry_cache #(.ADDR_W(8), .DATA_W(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
    .flush_done(flush_done),
    .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr),
    .C_data_w(C_data_w), .C_data_r(C_data_r), .C_out_valid(C_out_valid),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request (or a flush), answer bridge commands after lat cycles
  // with rd, and wait for the response pulse (or flush_done).
  task automatic run_op(input logic is_flush, input logic wr, input logic [7:0] addr,
                        input logic [63:0] data, input int lat, input logic [63:0] rd);
    int cd;
    int acc;
    bit done;
    cd   = -1;
    done = 1'b0;
    ncmd = 0;
    @(posedge clk); #1;
    if (is_flush) begin
      flush = 1'b1;
    end else begin
      req_valid = 1'b1; req_wr = wr; req_addr = addr; req_data = data;
    end
    acc = cyc;
    check("ready_before_op", {63'd0, req_ready}, 64'd1);
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0; C_out_valid = 1'b0;
      if (cd == 0) begin
        C_out_valid = 1'b1; C_data_r = rd; cd = -1;
      end else if (cd > 0) begin
        cd--;
      end
      @(negedge clk);
      if (C_in_valid) begin
        if (ncmd < 4) begin
          cmd_rwb[ncmd] = C_r_wb; cmd_addr[ncmd] = C_addr; cmd_dataw[ncmd] = C_data_w;
        end
        ncmd++;
        cd = lat - 1;
      end
      if (is_flush ? flush_done : rsp_valid) begin
        done = 1'b1; got_data = rsp_data; got_hit = rsp_hit; got_lat = cyc - acc;
      end
    end
    if (!done) check("op_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    C_out_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 8'h00;
    req_data = 64'd0; flush = 1'b0; C_data_r = 64'd0; C_out_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_c_in_valid", {63'd0, C_in_valid}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_hit_cnt", {48'd0, hit_cnt}, 64'd0);
    check("rst_miss_cnt", {48'd0, miss_cnt}, 64'd0);

    // Cold read miss, bridge answers 3 cycles after the command
    run_op(1'b0, 1'b0, 8'h05, 64'd0, 3, 64'h1122334455667788);
    check("cold_ncmd", ncmd, 1);
    check("cold_rwb", {63'd0, cmd_rwb[0]}, 64'd1);
    check("cold_addr", {56'd0, cmd_addr[0]}, 64'h05);
    check("cold_data", got_data, 64'h1122334455667788);
    check("cold_hit", {63'd0, got_hit}, 64'd0);
    check("cold_miss_cnt", {48'd0, miss_cnt}, 64'd1);

    // Read hit: latency 1, no bridge traffic
    run_op(1'b0, 1'b0, 8'h05, 64'd0, 1, 64'd0);
    check("rdhit_ncmd", ncmd, 0);
    check("rdhit_lat", got_lat, 1);
    check("rdhit_hit", {63'd0, got_hit}, 64'd1);
    check("rdhit_data", got_data, 64'h1122334455667788);
    check("rdhit_hit_cnt", {48'd0, hit_cnt}, 64'd1);

    // Write hit makes the entry dirty and echoes the new data
    run_op(1'b0, 1'b1, 8'h05, 64'hAAAAAAAAAAAAAAAA, 1, 64'd0);
    check("wrhit_ncmd", ncmd, 0);
    check("wrhit_lat", got_lat, 1);
    check("wrhit_hit", {63'd0, got_hit}, 64'd1);
    check("wrhit_data", got_data, 64'hAAAAAAAAAAAAAAAA);
    check("wrhit_hit_cnt", {48'd0, hit_cnt}, 64'd2);

    // Read miss over the dirty entry: write-back then fetch
    run_op(1'b0, 1'b0, 8'h09, 64'd0, 2, 64'h0909090909090909);
    check("wb_ncmd", ncmd, 2);
    check("wb_rwb", {63'd0, cmd_rwb[0]}, 64'd0);
    check("wb_addr", {56'd0, cmd_addr[0]}, 64'h05);
    check("wb_dataw", cmd_dataw[0], 64'hAAAAAAAAAAAAAAAA);
    check("wb_rd_rwb", {63'd0, cmd_rwb[1]}, 64'd1);
    check("wb_rd_addr", {56'd0, cmd_addr[1]}, 64'h09);
    check("wb_rsp_data", got_data, 64'h0909090909090909);
    check("wb_rsp_hit", {63'd0, got_hit}, 64'd0);
    check("wb_miss_cnt", {48'd0, miss_cnt}, 64'd2);

    // Write miss over the clean entry: install without a fetch
    run_op(1'b0, 1'b1, 8'h10, 64'h1010101010101010, 1, 64'd0);
    check("wrmiss_ncmd", ncmd, 0);
    check("wrmiss_lat", got_lat, 1);
    check("wrmiss_hit", {63'd0, got_hit}, 64'd0);
    check("wrmiss_data", got_data, 64'h1010101010101010);
    check("wrmiss_miss_cnt", {48'd0, miss_cnt}, 64'd3);

    // Flush of the dirty entry writes it back once
    run_op(1'b1, 1'b0, 8'h00, 64'd0, 2, 64'd0);
    check("flush_ncmd", ncmd, 1);
    check("flush_rwb", {63'd0, cmd_rwb[0]}, 64'd0);
    check("flush_addr", {56'd0, cmd_addr[0]}, 64'h10);
    check("flush_dataw", cmd_dataw[0], 64'h1010101010101010);

    // Second flush finds the entry clean: done next cycle
    run_op(1'b1, 1'b0, 8'h00, 64'd0, 1, 64'd0);
    check("flush2_ncmd", ncmd, 0);
    check("flush2_lat", got_lat, 1);

    // Flush keeps the entry valid
    run_op(1'b0, 1'b0, 8'h10, 64'd0, 1, 64'd0);
    check("postflush_hit", {63'd0, got_hit}, 64'd1);
    check("postflush_data", got_data, 64'h1010101010101010);
    check("postflush_hit_cnt", {48'd0, hit_cnt}, 64'd3);

    // Reset during RD_WAIT, late bridge completion must be ignored
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_issue", {63'd0, C_in_valid}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; C_out_valid = 1'b1; C_data_r = 64'hDEADBEEFDEADBEEF;
    @(negedge clk);
    check("abort_ready", {63'd0, req_ready}, 64'd1);
    check("abort_rsp0", {63'd0, rsp_valid}, 64'd0);
    @(posedge clk); #1;
    C_out_valid = 1'b0;
    @(negedge clk);
    check("abort_rsp1", {63'd0, rsp_valid}, 64'd0);
    check("abort_cin", {63'd0, C_in_valid}, 64'd0);
    check("abort_miss_cnt", {48'd0, miss_cnt}, 64'd0);

    // Entry was invalidated: 0x05 misses again
    run_op(1'b0, 1'b0, 8'h05, 64'd0, 1, 64'h5555555555555555);
    check("after_rst_ncmd", ncmd, 1);
    check("after_rst_addr", {56'd0, cmd_addr[0]}, 64'h05);
    check("after_rst_hit", {63'd0, got_hit}, 64'd0);
    check("after_rst_data", got_data, 64'h5555555555555555);
    check("after_rst_miss_cnt", {48'd0, miss_cnt}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
